// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback requester and regfile write-port bundle
interface wb_port_arbiter_if #(
   parameter int NREQ = 3,
   parameter int XLEN = 64,
   parameter int AW   = 5
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_waddr;
   logic [NREQ*XLEN-1:0] req_wdata;
   logic                 rf_we;
   logic [AW-1:0]        rf_waddr;
   logic [XLEN-1:0]      rf_wdata;
   logic [31:0]          pend_mask;

   modport master (
      output req_valid, req_waddr, req_wdata,
      input  req_ready, rf_we, rf_waddr, rf_wdata, pend_mask
   );

   modport slave (
      input  req_valid, req_waddr, req_wdata,
      output req_ready, rf_we, rf_waddr, rf_wdata, pend_mask
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin share of the regfile write port among writeback sources
module wb_port_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 64,
   parameter int AW   = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   wb_port_arbiter_if.slave   bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] full;
   logic [AW-1:0]   buf_addr [NREQ];
   logic [XLEN-1:0] buf_data [NREQ];
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   gnt_idx;
   logic            gnt_any;
   logic [NREQ-1:0] gnt_vec;
   logic [NREQ-1:0] accept;
   logic            rf_we_q;
   logic [AW-1:0]   rf_waddr_q;
   logic [XLEN-1:0] rf_wdata_q;
   logic [31:0]     pend;

   // First full buffer after the last winner; flush suppresses the grant.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (!flush) begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_any && full[idx]) begin
               gnt_any = 1'b1;
               gnt_idx = PW'(idx);
            end
         end
      end
      gnt_vec = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
   end

   assign bus.req_ready = {NREQ{rst_n & ~flush}} & (~full | gnt_vec);
   assign accept        = bus.req_valid & bus.req_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full       <= '0;
         ptr        <= PW'(NREQ - 1);
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_we_q <= gnt_any;
         if (gnt_any) begin
            rf_waddr_q <= buf_addr[gnt_idx];
            rf_wdata_q <= buf_data[gnt_idx];
            ptr        <= gnt_idx;
         end
         // A refill in the grant cycle keeps the buffer full; x0 writes are dropped.
         for (int i = 0; i < NREQ; i++) begin
            if (flush)
               full[i] <= 1'b0;
            else if (accept[i] && (bus.req_waddr[i*AW +: AW] != '0))
               full[i] <= 1'b1;
            else if (gnt_vec[i])
               full[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (accept[i]) begin
            buf_addr[i] <= bus.req_waddr[i*AW +: AW];
            buf_data[i] <= bus.req_wdata[i*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (full[i])
            pend = pend | (32'(1) << buf_addr[i]);
      end
      if (rf_we_q)
         pend = pend | (32'(1) << rf_waddr_q);
      bus.pend_mask = rst_n ? pend : 32'd0;
   end

   assign bus.rf_we    = rf_we_q;
   assign bus.rf_waddr = rf_waddr_q;
   assign bus.rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
   localparam int NREQ = 3;
   localparam int XLEN = 64;
   localparam int AW   = 5;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   wb_port_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();

   wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   wr_t sb_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   bit  sb_on   = 1'b1;

   always @(negedge clk) begin
      if (sb_on && rst_n && bus.rf_we === 1'b1) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_write: got addr=%0d data=%0h, required no write", bus.rf_waddr, bus.rf_wdata);
         end else begin
            wr_t e;
            e = sb_q.pop_front();
            if (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data) begin
               n_fail++;
               $display("FAIL sb_write: got addr=%0d data=%0h, required addr=%0d data=%0h", bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s, input bit v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      bus.req_valid[s]               = v;
      bus.req_waddr[s*AW +: AW]      = a;
      bus.req_wdata[s*XLEN +: XLEN]  = d;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      bus.req_valid = '0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_waddr = '0;
      bus.req_wdata = '0;
      step();
      step();
      n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b required 000", bus.req_ready); end
      n_tests++; if (bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL reset_pend: got %h required 0", bus.pend_mask); end
      n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b required 0", bus.rf_we); end
      n_tests++; if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 64'd0) begin n_fail++; $display("FAIL reset_rf: got %0d/%0h required 0/0", bus.rf_waddr, bus.rf_wdata); end
      rst_n = 1'b1;
      #1;
      n_tests++; if (bus.req_ready !== 3'b111) begin n_fail++; $display("FAIL reset_release_ready: got %b required 111", bus.req_ready); end
   endtask

   task automatic test_single();
      drive(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
      push(5'd5, 64'hDEAD_BEEF);
      #1;
      n_tests++; if (bus.req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b required 1", bus.req_ready[0]); end
      step();
      drive(0, 1'b0, 5'd0, 64'd0);
      n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL single_we_early: got %b required 0", bus.rf_we); end
      n_tests++; if (bus.pend_mask !== 32'h20) begin n_fail++; $display("FAIL single_pend_buf: got %h required 00000020", bus.pend_mask); end
      step();
      n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL single_write: got we=%b addr=%0d data=%h required 1/5/deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
      n_tests++; if (bus.pend_mask !== 32'h20) begin n_fail++; $display("FAIL single_pend_rf: got %h required 00000020", bus.pend_mask); end
      step();
      n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL single_we_once: got %b required 0", bus.rf_we); end
      n_tests++; if (bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL single_pend_clear: got %h required 0", bus.pend_mask); end
      n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d pending required 0", sb_q.size()); end
   endtask

   task automatic test_x0();
      drive(1, 1'b1, 5'd0, 64'h1234);
      #1;
      n_tests++; if (bus.req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b required 1", bus.req_ready[1]); end
      step();
      drive(1, 1'b0, 5'd0, 64'd0);
      n_tests++; if (bus.rf_we !== 1'b0 || bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL x0_no_load: got we=%b pend=%h required 0/0", bus.rf_we, bus.pend_mask); end
      step();
      n_tests++; if (bus.rf_we !== 1'b0 || bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL x0_no_write: got we=%b pend=%h required 0/0", bus.rf_we, bus.pend_mask); end
   endtask

   task automatic test_back_to_back();
      int cnt[NREQ];
      do_reset();
      for (int s = 0; s < NREQ; s++) begin
         cnt[s] = 0;
         drive(s, 1'b1, AW'(s + 1), {32'(s), 32'(0)});
      end
      #1;
      n_tests++; if (bus.req_ready !== 3'b111) begin n_fail++; $display("FAIL b2b_ready_first: got %b required 111", bus.req_ready); end
      for (int s = 0; s < NREQ; s++) push(AW'(s + 1), {32'(s), 32'(0)});
      step();
      for (int s = 0; s < NREQ; s++) begin
         cnt[s] = 1;
         drive(s, 1'b1, AW'(s + 1), {32'(s), 32'(1)});
      end
      for (int k = 1; k <= 9; k++) begin
         int s;
         logic [NREQ-1:0] exp_rdy;
         s = (k - 1) % NREQ;
         exp_rdy = NREQ'(1) << s;
         #1;
         n_tests++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready k=%0d: got %b required %b", k, bus.req_ready, exp_rdy); end
         if (k >= 2) begin
            n_tests++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL b2b_we k=%0d: got %b required 1", k, bus.rf_we); end
         end
         push(AW'(s + 1), {32'(s), 32'(cnt[s])});
         step();
         cnt[s]++;
         drive(s, 1'b1, AW'(s + 1), {32'(s), 32'(cnt[s])});
      end
      bus.req_valid = '0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_tests++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL b2b_drain_we k=%0d: got %b required 1", k, bus.rf_we); end
      end
      step();
      n_tests++; if (bus.rf_we !== 1'b0 || sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_done: got we=%b pending=%0d required 0/0", bus.rf_we, sb_q.size()); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(0, 1'b1, 5'd7, 64'h7777);
      push(5'd7, 64'h7777);
      step();
      drive(0, 1'b1, 5'd9, 64'h9999);
      drive(2, 1'b1, 5'd11, 64'hBBBB);
      #1;
      n_tests++; if (bus.req_ready !== 3'b111) begin n_fail++; $display("FAIL flush_pre_ready: got %b required 111", bus.req_ready); end
      step();
      flush = 1'b1;
      drive(0, 1'b0, 5'd0, 64'd0);
      drive(2, 1'b0, 5'd0, 64'd0);
      drive(1, 1'b1, 5'd12, 64'hCCCC);
      #1;
      n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL flush_ready: got %b required 000", bus.req_ready); end
      n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7) begin n_fail++; $display("FAIL flush_committed: got we=%b addr=%0d required 1/7", bus.rf_we, bus.rf_waddr); end
      n_tests++; if (bus.pend_mask !== 32'h0000_0A80) begin n_fail++; $display("FAIL flush_pend_pre: got %h required 00000a80", bus.pend_mask); end
      step();
      flush = 1'b0;
      drive(1, 1'b0, 5'd0, 64'd0);
      #1;
      n_tests++; if (bus.rf_we !== 1'b0 || bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL flush_cleared: got we=%b pend=%h required 0/0", bus.rf_we, bus.pend_mask); end
      step();
      n_tests++; if (bus.rf_we !== 1'b0 || sb_q.size() != 0) begin n_fail++; $display("FAIL flush_after: got we=%b pending=%0d required 0/0", bus.rf_we, sb_q.size()); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(0, 1'b1, 5'd13, 64'h13);
      drive(1, 1'b1, 5'd14, 64'h14);
      drive(2, 1'b1, 5'd15, 64'h15);
      step();
      bus.req_valid = '0;
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus.req_ready !== 3'b000 || bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL rmid_in_reset: got ready=%b pend=%h required 000/0", bus.req_ready, bus.pend_mask); end
      step();
      rst_n = 1'b1;
      #1;
      n_tests++; if (bus.rf_we !== 1'b0 || bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL rmid_lost: got we=%b pend=%h required 0/0", bus.rf_we, bus.pend_mask); end
      drive(0, 1'b1, 5'd4, 64'h44);
      drive(1, 1'b1, 5'd5, 64'h55);
      drive(2, 1'b1, 5'd6, 64'h66);
      push(5'd4, 64'h44);
      push(5'd5, 64'h55);
      push(5'd6, 64'h66);
      step();
      bus.req_valid = '0;
      step();
      n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4) begin n_fail++; $display("FAIL rmid_first_grant: got we=%b addr=%0d required 1/4", bus.rf_we, bus.rf_waddr); end
      step();
      step();
      step();
      n_tests++; if (bus.rf_we !== 1'b0 || sb_q.size() != 0) begin n_fail++; $display("FAIL rmid_drain: got we=%b pending=%0d required 0/0", bus.rf_we, sb_q.size()); end
   endtask

   task automatic test_starvation();
      int gap;
      do_reset();
      sb_on = 1'b0;
      gap = 0;
      drive(2, 1'b1, 5'd20, 64'h20);
      for (int c = 0; c < 30; c++) begin
         drive(0, 1'($urandom % 2), 5'd21, 64'h21);
         drive(1, 1'($urandom % 2), 5'd22, 64'h22);
         step();
         if (c >= 1) begin
            n_tests++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL starve_we c=%0d: got %b required 1", c, bus.rf_we); end
            if (bus.rf_we === 1'b1 && bus.rf_waddr === 5'd20) gap = 0;
            else gap++;
            n_tests++; if (gap >= NREQ) begin n_fail++; $display("FAIL starve_gap c=%0d: got gap %0d required < %0d", c, gap, NREQ); end
         end
      end
      bus.req_valid = '0;
      for (int k = 0; k < 4; k++) step();
      n_tests++; if (bus.rf_we !== 1'b0 || bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL starve_drain: got we=%b pend=%h required 0/0", bus.rf_we, bus.pend_mask); end
      sb_q.delete();
      sb_on = 1'b1;
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_waddr = '0;
      bus.req_wdata = '0;
      test_reset();
      test_single();
      test_x0();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_starvation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
